// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size encodings, FSM states and big-endian lane helper for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_FAULT
    } lsu_state_e;

    // Right-shift that brings byte offset N down to bits 7:0 (offset 0 sits in bits 31:24)
    localparam logic [4:0] LANE_SHIFT [4] = '{5'd24, 5'd16, 5'd8, 5'd0};

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load extract/extend and store lane merge for the load/store unit
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] merge_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [4:0]  shift;
    logic [31:0] lane_mask;
    logic [31:0] shifted;

    always_comb begin
        shift     = 5'd0;
        lane_mask = '1;
        case (size_i)
            SZ_BYTE: begin
                shift     = LANE_SHIFT[offset_i];
                lane_mask = 32'h0000_00FF << shift;
            end
            // halfword ignores offset bit 0, so it always lands on lane 0-1 or 2-3
            SZ_HALF: begin
                shift     = LANE_SHIFT[{offset_i[1], 1'b1}];
                lane_mask = 32'h0000_FFFF << shift;
            end
            default: ;
        endcase

        shifted     = rdata_i >> shift;
        load_data_o = shifted;
        case (size_i)
            SZ_BYTE: load_data_o = {{24{~unsigned_i & shifted[7]}},  shifted[7:0]};
            SZ_HALF: load_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase

        // a full-word mask makes this pass wdata straight through for word stores
        store_data_o = (merge_i & ~lane_mask) | ((wdata_i << shift) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit in front of a word-addressed data memory
// Optional feature: LSU_MISALIGN_CHECK_EN enables misalignment detection and the FAULT state.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              accept;
    logic              misaligned;
    logic [31:0]       load_data;
    logic [31:0]       store_data;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    lsu_align u_align (
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .offset_i     (addr_q[1:0]),
        .rdata_i      (mem_rdata),
        .wdata_i      (wdata_q),
        .merge_i      (merge_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!req_write)       state_d = ST_LOAD;
                    else if (req_size[1]) state_d = ST_WRITE;
                    else                  state_d = ST_RMW_RD;
                    if (misaligned)       state_d = ST_FAULT;
                end
            end
            ST_LOAD: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
                state_d      = ST_IDLE;
            end
            ST_RMW_RD: state_d = ST_WRITE;
            ST_WRITE: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                state_d      = ST_IDLE;
            end
            ST_FAULT: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
            end
            if (state_q == ST_RMW_RD) merge_q <= mem_rdata;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic resp_mis_q;

    always_ff @(posedge clk) begin
        if (!rst_n)            resp_mis_q <= 1'b0;
        else if (resp_valid_d) resp_mis_q <= (state_q == ST_FAULT);
    end

    assign resp_misaligned = resp_mis_q;
`else
    assign resp_misaligned = 1'b0;
`endif

    // memory side decodes only registered state so it is stable across the negedge commit
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_read   = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    assign mem_write  = (state_q == ST_WRITE);
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = (state_q == ST_WRITE) ? store_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a byte-array model
module tb_load_store_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    logic [31:0] env_mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    logic [7:0]  ref_bytes [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_rdata       (mem_rdata)
    );

    assign mem_rdata = env_mem[mem_addr[7:2]];

    always @(negedge clk) begin
        if (pl_en)          env_mem[pl_idx] <= pl_val;
        else if (mem_write) env_mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_bytes[4*idx], ref_bytes[4*idx+1], ref_bytes[4*idx+2], ref_bytes[4*idx+3]};
    endfunction

    task automatic set_word(input int idx, input logic [31:0] val);
        pl_idx = 6'(idx);
        pl_val = val;
        pl_en  = 1'b1;
        for (int i = 0; i < 4; i++) ref_bytes[4*idx+i] = val[31-8*i -: 8];
        @(negedge clk);
        #1 pl_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a posedge; returns 1 time unit after the response edge.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        int          nb, ea, exp_n, exp_r, exp_w, n, rd_cnt, wr_cnt;
        logic        exp_mis;
        logic [31:0] v, exp_rd;

        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ea = (int'(a[7:0]) / nb) * nb;
`ifdef LSU_MISALIGN_CHECK_EN
        exp_mis = (int'(a[7:0]) % nb) != 0;
`else
        exp_mis = 1'b0;
`endif
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_bytes[ea+i]);
        if (!u && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!u && nb == 2 && v[15]) v = v | 32'hFFFF_0000;

        if (exp_mis)      begin exp_n = 1; exp_r = 0; exp_w = 0; exp_rd = 32'h0; end
        else if (!w)      begin exp_n = 1; exp_r = 1; exp_w = 0; exp_rd = v; end
        else if (nb == 4) begin exp_n = 1; exp_r = 0; exp_w = 1; exp_rd = 32'h0; end
        else              begin exp_n = 2; exp_r = 1; exp_w = 1; exp_rd = 32'h0; end

        if (w && !exp_mis)
            for (int i = 0; i < nb; i++) ref_bytes[ea+i] = 8'(wd >> (8*(nb-1-i)));

        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        n = 0; rd_cnt = 0; wr_cnt = 0;
        while (!resp_valid && n < 8) begin
            rd_cnt += int'(mem_read);
            wr_cnt += int'(mem_write);
            if (mem_read || mem_write)
                check_eq("mem_addr", mem_addr, 32'(ea & ~3));
            @(posedge clk);
            #1 n++;
        end
        got = resp_rdata;
        check_eq("resp_valid", 32'(resp_valid), 32'd1);
        check_eq("latency", 32'(n), 32'(exp_n));
        check_eq("mem_read_cycles", 32'(rd_cnt), 32'(exp_r));
        check_eq("mem_write_cycles", 32'(wr_cnt), 32'(exp_w));
        check_eq("resp_rdata", resp_rdata, exp_rd);
        check_eq("resp_misaligned", 32'(resp_misaligned), 32'(exp_mis));
        check_eq("mem_word", env_mem[ea/4], ref_word(ea/4));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          wr_seen;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_resp_mis", 32'(resp_misaligned), 32'd0);
        check_eq("rst_mem_read", 32'(mem_read), 32'd0);
        check_eq("rst_mem_write", 32'(mem_write), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) set_word(i, $urandom);

        set_word(4, 32'h8122F344);
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, got); check_eq("tp_lb",  got, 32'hFFFFFF81);
        do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, got); check_eq("tp_lbu", got, 32'h00000081);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, got); check_eq("tp_lh",  got, 32'hFFFFF344);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got); check_eq("tp_lw",  got, 32'h8122F344);

        set_word(4, 32'h11223344);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAB, got);
        check_eq("tp_sb_mem", env_mem[4], 32'h11AB3344);
        set_word(4, 32'h11223344);
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, got);
        check_eq("tp_sh_mem", env_mem[4], 32'h1122BEEF);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, got);
        check_eq("tp_sw_mem", env_mem[4], 32'hDEADBEEF);

        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, got);
`ifdef LSU_MISALIGN_CHECK_EN
        check_eq("tp_lw_misaligned", got, 32'h0);
`else
        check_eq("tp_lw_misaligned", got, 32'hDEADBEEF);
`endif

        // reset while the sub-word store sits in its read phase
        req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_eq("abort_in_rmw_rd", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        wr_seen = 0;
        @(posedge clk);
        #1;
        wr_seen += int'(mem_write);
        check_eq("abort_req_ready", 32'(req_ready), 32'd1);
        check_eq("abort_resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1 wr_seen += int'(mem_write);
        end
        check_eq("abort_no_write", 32'(wr_seen), 32'd0);
        check_eq("abort_mem_word", env_mem[4], 32'hDEADBEEF);

        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got);
        check_eq("b2b_lw", got, 32'hCAFEF00D);

        for (int k = 0; k < 300; k++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   32'($urandom_range(0, 255)), $urandom, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
